// File: rtl/lc_tag_collector_if.sv
// Tag output stream toward the event builder: valid/ready handshake carrying
// the channel index and whether the trigger was confirmed by a local coincidence.
interface lc_tag_collector_if;
    logic       tag_valid;
    logic       tag_ready;
    logic [7:0] tag_chan;
    logic       tag_lc;

    modport master (
        output tag_valid,
        output tag_chan,
        output tag_lc,
        input  tag_ready
    );

    modport slave (
        input  tag_valid,
        input  tag_chan,
        input  tag_lc,
        output tag_ready
    );
endinterface

// File: rtl/lc_tag_collector.sv
// Turns each per-channel trigger rising edge into one tag (confirmed or timed out)
// and serializes pending tags round-robin onto a single valid/ready stream.
module lc_tag_collector #(
    parameter int N_CHANNELS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           lc_window_width,
    input  logic [N_CHANNELS-1:0] trig,
    input  logic [N_CHANNELS-1:0] local_coinc,
    lc_tag_collector_if.master    tag_if,
    output logic [15:0]           drop_count
);

    // state   | meaning
    // ST_IDLE | armed, waiting for a trigger rising edge
    // ST_WAIT | edge seen, watching local_coinc until the window expires
    // ST_PEND | outcome known, waiting for the arbiter to take the tag
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PEND = 2'd2
    } ch_state_t;

    ch_state_t             state_q   [N_CHANNELS];
    ch_state_t             state_nxt [N_CHANNELS];
    logic [15:0]           cnt_q     [N_CHANNELS];
    logic [15:0]           cnt_nxt   [N_CHANNELS];
    logic [N_CHANNELS-1:0] lc_q;
    logic [N_CHANNELS-1:0] lc_nxt;
    logic [N_CHANNELS-1:0] trig_d;
    logic [N_CHANNELS-1:0] trig_edge;
    logic [N_CHANNELS-1:0] pend_vec;
    logic [N_CHANNELS-1:0] drop_vec;

    logic [7:0]            rr_q;
    logic [7:0]            rr_nxt;
    logic                  tag_valid_q;
    logic                  tag_valid_nxt;
    logic [7:0]            tag_chan_q;
    logic [7:0]            tag_chan_nxt;
    logic                  tag_lc_q;
    logic                  tag_lc_nxt;
    logic [15:0]           drop_count_q;
    logic [15:0]           drop_count_nxt;

    logic [15:0]           win_eff;
    logic                  out_free;
    logic                  pend_found;
    logic                  grant;
    logic [7:0]            grant_idx;
    logic                  grant_lc;
    logic                  hi_hit;
    logic [7:0]            hi_idx;
    logic                  lo_hit;
    logic [7:0]            lo_idx;
    logic [8:0]            drop_pop;
    logic [16:0]           drop_sum;

    assign win_eff   = (lc_window_width == 16'd0) ? 16'd1 : lc_window_width;
    assign trig_edge = trig & ~trig_d;
    assign out_free  = ~tag_valid_q | tag_if.tag_ready;

    // Round-robin pick: first PEND at or above rr, else the lowest PEND (wrap).
    always_comb begin
        pend_vec = '0;
        hi_hit   = 1'b0;
        hi_idx   = '0;
        lo_hit   = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            pend_vec[i] = (state_q[i] == ST_PEND);
            if (pend_vec[i] && !lo_hit) begin
                lo_hit = 1'b1;
                lo_idx = 8'(i);
            end
            if (pend_vec[i] && !hi_hit && (8'(i) >= rr_q)) begin
                hi_hit = 1'b1;
                hi_idx = 8'(i);
            end
        end
        pend_found = lo_hit;
        grant_idx  = hi_hit ? hi_idx : lo_idx;
        grant      = pend_found & out_free;
        grant_lc   = 1'b0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (grant_idx == 8'(i)) begin
                grant_lc = lc_q[i];
            end
        end
    end

    // Per-channel collection FSMs.
    always_comb begin
        drop_vec = '0;
        lc_nxt   = lc_q;
        for (int i = 0; i < N_CHANNELS; i++) begin
            state_nxt[i] = state_q[i];
            cnt_nxt[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (trig_edge[i]) begin
                        if (local_coinc[i]) begin
                            state_nxt[i] = ST_PEND;
                            lc_nxt[i]    = 1'b1;
                            cnt_nxt[i]   = '0;
                        end else begin
                            state_nxt[i] = ST_WAIT;
                            lc_nxt[i]    = 1'b0;
                            cnt_nxt[i]   = 16'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    drop_vec[i] = trig_edge[i];
                    // Coincidence wins over timeout; timeout check keeps cnt from wrapping.
                    if (local_coinc[i]) begin
                        state_nxt[i] = ST_PEND;
                        lc_nxt[i]    = 1'b1;
                        cnt_nxt[i]   = '0;
                    end else if (cnt_q[i] >= win_eff) begin
                        state_nxt[i] = ST_PEND;
                        lc_nxt[i]    = 1'b0;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = cnt_q[i] + 16'd1;
                    end
                end
                ST_PEND: begin
                    drop_vec[i] = trig_edge[i];
                    if (grant && (grant_idx == 8'(i))) begin
                        state_nxt[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt[i] = ST_IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Saturating drop accumulation.
    always_comb begin
        drop_pop = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            drop_pop = drop_pop + {8'd0, drop_vec[i]};
        end
        drop_sum       = {1'b0, drop_count_q} + {8'd0, drop_pop};
        drop_count_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_comb begin
        tag_valid_nxt = tag_valid_q;
        tag_chan_nxt  = tag_chan_q;
        tag_lc_nxt    = tag_lc_q;
        rr_nxt        = rr_q;
        if (out_free) begin
            if (pend_found) begin
                tag_valid_nxt = 1'b1;
                tag_chan_nxt  = grant_idx;
                tag_lc_nxt    = grant_lc;
                rr_nxt        = (grant_idx == 8'(N_CHANNELS - 1)) ? 8'd0 : grant_idx + 8'd1;
            end else begin
                tag_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            lc_q         <= '0;
            trig_d       <= '0;
            rr_q         <= '0;
            tag_valid_q  <= 1'b0;
            tag_chan_q   <= '0;
            tag_lc_q     <= 1'b0;
            drop_count_q <= '0;
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                state_q[i] <= state_nxt[i];
                cnt_q[i]   <= cnt_nxt[i];
            end
            lc_q         <= lc_nxt;
            trig_d       <= trig;
            rr_q         <= rr_nxt;
            tag_valid_q  <= tag_valid_nxt;
            tag_chan_q   <= tag_chan_nxt;
            tag_lc_q     <= tag_lc_nxt;
            drop_count_q <= drop_count_nxt;
        end
    end

    assign tag_if.tag_valid = tag_valid_q;
    assign tag_if.tag_chan  = tag_chan_q;
    assign tag_if.tag_lc    = tag_lc_q;
    assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_lc_tag_collector.sv
// Bench for lc_tag_collector: vector table, corner sequences and random traffic
// checked every cycle against a timestamp-based reference model.
module tb_lc_tag_collector;
    localparam int N = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   win;
    logic [N-1:0]  trig;
    logic [N-1:0]  coinc;
    logic [15:0]   drop_count;

    lc_tag_collector_if tag_if ();

    lc_tag_collector #(.N_CHANNELS(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .lc_window_width (win),
        .trig            (trig),
        .local_coinc     (coinc),
        .tag_if          (tag_if.master),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;

    // Reference model: a channel either has an open window (edge timestamp),
    // a finished outcome waiting to be sent, or nothing.
    bit [N-1:0] m_trig_prev;
    bit         m_open [N];
    longint     m_since [N];
    bit         m_pend [N];
    bit         m_plc [N];
    bit         m_valid;
    int         m_chan;
    bit         m_lc;
    int         m_rr;
    int         m_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit [N-1:0] edges;
        bit         free;
        int         g;
        int         weff;
        int         drops;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_open[i] = 0; m_pend[i] = 0; m_plc[i] = 0; m_since[i] = 0;
            end
            m_trig_prev = '0; m_valid = 0; m_chan = 0; m_lc = 0; m_rr = 0; m_drops = 0;
            return;
        end
        edges = trig & ~m_trig_prev;
        m_trig_prev = trig;
        weff = (win == 16'd0) ? 1 : int'(win);
        free = !m_valid || tag_if.tag_ready;
        g = -1;
        if (free) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        drops = 0;
        for (int i = 0; i < N; i++) begin
            if ((m_open[i] || m_pend[i]) && edges[i]) drops++;
            if (m_pend[i]) begin
                if (i == g) m_pend[i] = 0;
            end else if (m_open[i]) begin
                if (coinc[i]) begin
                    m_open[i] = 0; m_pend[i] = 1; m_plc[i] = 1;
                end else if (cyc - m_since[i] >= longint'(weff)) begin
                    m_open[i] = 0; m_pend[i] = 1; m_plc[i] = 0;
                end
            end else if (edges[i]) begin
                if (coinc[i]) begin
                    m_pend[i] = 1; m_plc[i] = 1;
                end else begin
                    m_open[i] = 1; m_since[i] = cyc;
                end
            end
        end
        m_drops = (m_drops + drops > 65535) ? 65535 : m_drops + drops;
        if (free) begin
            if (g >= 0) begin
                m_valid = 1; m_chan = g; m_lc = m_plc[g]; m_rr = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        chk("tag_valid", 32'(tag_if.tag_valid), 32'(m_valid));
        if (m_valid) begin
            chk("tag_chan", 32'(tag_if.tag_chan), 32'(m_chan));
            chk("tag_lc", 32'(tag_if.tag_lc), 32'(m_lc));
        end
        chk("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    function automatic logic [N-1:0] ch(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    typedef struct {
        logic [N-1:0] trig;
        logic [N-1:0] coinc;
        logic         ready;
        logic         rst;
        logic         exp_valid;
        logic [7:0]   exp_chan;
        logic         exp_lc;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] t, input logic [N-1:0] c, input logic r,
                                input logic rs, input logic v, input logic [7:0] chn, input logic l);
        vec_t e;
        e.trig = t; e.coinc = c; e.ready = r; e.rst = rs;
        e.exp_valid = v; e.exp_chan = chn; e.exp_lc = l;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[$];
        logic [N-1:0] z;
        logic [N-1:0] arb_a;
        logic [N-1:0] arb_b;
        logic [N-1:0] bp;
        int           d0;
        int           exp_hold_chan;
        int           exp_hold_lc;
        int           seen [N];
        int           n4;

        z = '0;
        trig = '0; coinc = '0; win = 16'd10; tag_if.tag_ready = 1'b0; rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        arb_a = ch(2) | ch(7) | ch(20);
        arb_b = ch(1) | ch(21);
        // Single confirmed on ch3, then reset so rr restarts at 0 for arbitration.
        tbl.push_back(mk(z,     z,     1'b0, 1'b0, 1'b0, 8'd0,  1'b0));
        tbl.push_back(mk(z,     z,     1'b0, 1'b0, 1'b0, 8'd0,  1'b0));
        tbl.push_back(mk(ch(3), ch(3), 1'b0, 1'b0, 1'b0, 8'd0,  1'b0));
        tbl.push_back(mk(ch(3), z,     1'b0, 1'b0, 1'b1, 8'd3,  1'b1));
        tbl.push_back(mk(z,     z,     1'b0, 1'b0, 1'b1, 8'd3,  1'b1));
        tbl.push_back(mk(z,     z,     1'b0, 1'b0, 1'b1, 8'd3,  1'b1));
        tbl.push_back(mk(z,     z,     1'b1, 1'b0, 1'b0, 8'd0,  1'b0));
        tbl.push_back(mk(z,     z,     1'b1, 1'b1, 1'b0, 8'd0,  1'b0));
        tbl.push_back(mk(arb_a, arb_a, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0));
        tbl.push_back(mk(arb_a, z,     1'b1, 1'b0, 1'b1, 8'd2,  1'b1));
        tbl.push_back(mk(arb_a, z,     1'b1, 1'b0, 1'b1, 8'd7,  1'b1));
        tbl.push_back(mk(arb_a, z,     1'b1, 1'b0, 1'b1, 8'd20, 1'b1));
        tbl.push_back(mk(z,     z,     1'b1, 1'b0, 1'b0, 8'd0,  1'b0));
        tbl.push_back(mk(arb_b, arb_b, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0));
        tbl.push_back(mk(z,     z,     1'b1, 1'b0, 1'b1, 8'd21, 1'b1));
        tbl.push_back(mk(z,     z,     1'b1, 1'b0, 1'b1, 8'd1,  1'b1));
        tbl.push_back(mk(z,     z,     1'b1, 1'b0, 1'b0, 8'd0,  1'b0));

        for (int r = 0; r < tbl.size(); r++) begin
            trig = tbl[r].trig; coinc = tbl[r].coinc;
            tag_if.tag_ready = tbl[r].ready; rst = tbl[r].rst;
            step();
            chk($sformatf("tbl%0d_valid", r), 32'(tag_if.tag_valid), 32'(tbl[r].exp_valid));
            if (tbl[r].exp_valid) begin
                chk($sformatf("tbl%0d_chan", r), 32'(tag_if.tag_chan), 32'(tbl[r].exp_chan));
                chk($sformatf("tbl%0d_lc", r), 32'(tag_if.tag_lc), 32'(tbl[r].exp_lc));
            end
        end
        rst = 1'b0; trig = '0; coinc = '0; tag_if.tag_ready = 1'b1;
        repeat (3) step();

        // Late confirm at t+10 with W=10.
        win = 16'd10;
        trig = ch(0); step();
        repeat (9) step();
        coinc = ch(0); step();
        coinc = '0;
        chk("late_not_yet", 32'(tag_if.tag_valid), 32'd0);
        step();
        chk("late_valid", 32'(tag_if.tag_valid), 32'd1);
        chk("late_chan", 32'(tag_if.tag_chan), 32'd0);
        chk("late_lc", 32'(tag_if.tag_lc), 32'd1);
        trig = '0; repeat (3) step();

        // Flag at t+11 is too late: timeout tag, flag ignored.
        trig = ch(0); step();
        repeat (10) step();
        chk("to_not_yet", 32'(tag_if.tag_valid), 32'd0);
        coinc = ch(0); step();
        chk("to_valid", 32'(tag_if.tag_valid), 32'd1);
        chk("to_lc", 32'(tag_if.tag_lc), 32'd0);
        coinc = '0; trig = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("to_no_extra", 32'(tag_if.tag_valid), 32'd0);
        end

        // W=0 behaves as W=1: flag at t+1 confirms, flag at t+2 is too late.
        win = 16'd0;
        trig = ch(5); step();
        coinc = ch(5); step();
        coinc = '0; step();
        chk("w0_conf_valid", 32'(tag_if.tag_valid), 32'd1);
        chk("w0_conf_lc", 32'(tag_if.tag_lc), 32'd1);
        trig = '0; repeat (3) step();
        trig = ch(5); step();
        step();
        coinc = ch(5); step();
        chk("w0_to_valid", 32'(tag_if.tag_valid), 32'd1);
        chk("w0_to_lc", 32'(tag_if.tag_lc), 32'd0);
        coinc = '0; trig = '0; repeat (3) step();

        // Backpressure: 5 pending, tag held for 50 cycles, then each drains once.
        win = 16'd10;
        bp = ch(5) | ch(9) | ch(10) | ch(15) | ch(23);
        tag_if.tag_ready = 1'b0;
        trig = bp; coinc = bp; step();
        trig = '0; coinc = '0; step();
        exp_hold_chan = m_chan;
        exp_hold_lc = int'(m_lc);
        for (int k = 0; k < 50; k++) begin
            step();
            chk("bp_hold_valid", 32'(tag_if.tag_valid), 32'd1);
            chk("bp_hold_chan", 32'(tag_if.tag_chan), 32'(exp_hold_chan));
            chk("bp_hold_lc", 32'(tag_if.tag_lc), 32'(exp_hold_lc));
        end
        for (int i = 0; i < N; i++) seen[i] = 0;
        if (tag_if.tag_valid) seen[tag_if.tag_chan]++;
        tag_if.tag_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (tag_if.tag_valid) seen[tag_if.tag_chan]++;
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("bp_seen_ch%0d", i), 32'(seen[i]), bp[i] ? 32'd1 : 32'd0);
        end

        // Drops: one re-edge during WAIT, then three simultaneous.
        d0 = m_drops;
        trig = ch(4); step();
        trig = '0; step();
        trig = ch(4); step();
        chk("drop_one", 32'(drop_count), 32'(d0 + 1));
        trig = '0;
        n4 = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (tag_if.tag_valid && tag_if.tag_chan == 8'd4) n4++;
        end
        chk("drop_one_tag", 32'(n4), 32'd1);
        d0 = m_drops;
        trig = ch(6) | ch(7) | ch(8); step();
        trig = '0; step();
        trig = ch(6) | ch(7) | ch(8); step();
        chk("drop_three", 32'(drop_count), 32'(d0 + 3));
        trig = '0; repeat (15) step();

        // Saturation: park all channels in a long window and toggle triggers.
        win = 16'hFFFF;
        trig = '1; step();
        trig = '0; step();
        for (int k = 0; k < 2800; k++) begin
            trig = '1; step();
            trig = '0; step();
        end
        chk("drop_sat", 32'(drop_count), 32'hFFFF);
        trig = '1; step();
        trig = '0; step();
        chk("drop_sat_hold", 32'(drop_count), 32'hFFFF);
        win = 16'd1;
        repeat (30) step();

        // Reset while a tag is held and four more are pending.
        win = 16'd10;
        tag_if.tag_ready = 1'b0;
        trig = ch(11) | ch(12) | ch(13) | ch(14) | ch(16);
        coinc = trig; step();
        trig = '0; coinc = '0; step();
        chk("rst_pre_valid", 32'(tag_if.tag_valid), 32'd1);
        rst = 1'b1; step();
        chk("rst_valid", 32'(tag_if.tag_valid), 32'd0);
        chk("rst_chan", 32'(tag_if.tag_chan), 32'd0);
        chk("rst_lc", 32'(tag_if.tag_lc), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        rst = 1'b0; tag_if.tag_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("rst_quiet", 32'(tag_if.tag_valid), 32'd0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) win = 16'($urandom_range(0, 8));
            trig = trig ^ N'($urandom & $urandom & $urandom);
            coinc = N'($urandom & $urandom & $urandom);
            tag_if.tag_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
